// File: rtl/hazard_sequencer_if.sv
// Decode-side and pipeline-control signals between the ID control unit and the hazard sequencer.
interface hazard_sequencer_if #(
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_wen;
    logic            id_lw;
    logic            ex_redirect;
    logic            mem_busy;

    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen, id_lw,
        output ex_redirect, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen, id_lw,
        input  ex_redirect, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for a 5-stage pipeline: scoreboard of in-flight writers,
// stage enable/bubble/flush generation, registered EX forwarding selects and
// saturating stall/redirect counters.
//
// The MEM/WB scoreboard entry is not stored: the register file writes before
// it reads, so a WB-stage writer never causes a hazard, and the forwarding
// selects are computed while the writer is still in E or M.
module hazard_sequencer #(
    parameter int FORWARDING = 1,
    parameter int REGW       = 5,
    parameter int CNTW       = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        CL_RUN,
        CL_STALL,
        CL_REDIRECT,
        CL_FREEZE
    } cycle_class_e;

    logic            r_e_valid;
    logic [REGW-1:0] r_e_rd;
    logic            r_e_lw;
    logic            r_m_valid;
    logic [REGW-1:0] r_m_rd;
    logic [1:0]      r_fwd_a;
    logic [1:0]      r_fwd_b;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    logic            w_e_a;
    logic            w_e_b;
    logic            w_m_a;
    logic            w_m_b;
    logic            w_hazard;
    cycle_class_e    w_class;

    function automatic logic f_match(input logic v, input logic [REGW-1:0] rd,
                                     input logic [REGW-1:0] rs, input logic use_rs);
        return v && (rd != '0) && (rd == rs) && use_rs;
    endfunction

    // Youngest producer wins: EX/MEM result before MEM/WB result.
    function automatic logic [1:0] f_sel(input logic e_hit, input logic m_hit);
        if (e_hit) return 2'b01;
        if (m_hit) return 2'b10;
        return 2'b00;
    endfunction

    assign w_e_a = f_match(r_e_valid, r_e_rd, bus.id_rs1, bus.id_use_rs1);
    assign w_e_b = f_match(r_e_valid, r_e_rd, bus.id_rs2, bus.id_use_rs2);
    assign w_m_a = f_match(r_m_valid, r_m_rd, bus.id_rs1, bus.id_use_rs1);
    assign w_m_b = f_match(r_m_valid, r_m_rd, bus.id_rs2, bus.id_use_rs2);

    // With forwarding only a load result is too late for the next instruction.
    assign w_hazard = (FORWARDING != 0) ? ((w_e_a | w_e_b) & r_e_lw)
                                        : (w_e_a | w_e_b | w_m_a | w_m_b);

    // Classify the cycle; memory busy dominates because EX must hold its redirect.
    always_comb begin
        w_class = CL_RUN;
        if (bus.mem_busy)                   w_class = CL_FREEZE;
        else if (bus.ex_redirect)           w_class = CL_REDIRECT;
        else if (bus.id_valid && w_hazard)  w_class = CL_STALL;
    end

    // Drive stage enables, flush and bubble from the cycle class.
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
        case (w_class)
            CL_FREEZE: begin
                bus.pc_en    = 1'b0;
                bus.ifid_en  = 1'b0;
                bus.idex_en  = 1'b0;
                bus.exmem_en = 1'b0;
                bus.memwb_en = 1'b0;
            end
            CL_REDIRECT: begin
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end
            CL_STALL: begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // Advance scoreboard, forwarding selects and counters on every non-freeze cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_e_valid   <= 1'b0;
            r_e_rd      <= '0;
            r_e_lw      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_rd      <= '0;
            r_fwd_a     <= 2'b00;
            r_fwd_b     <= 2'b00;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_class != CL_FREEZE) begin
            r_m_valid <= r_e_valid;
            r_m_rd    <= r_e_rd;
            if (w_class == CL_RUN) begin
                r_e_valid <= bus.id_valid & bus.id_wen;
                r_e_rd    <= bus.id_rd;
                r_e_lw    <= bus.id_lw;
            end else begin
                r_e_valid <= 1'b0;
                r_e_rd    <= '0;
                r_e_lw    <= 1'b0;
            end
            if ((w_class == CL_RUN) && (FORWARDING != 0)) begin
                r_fwd_a <= f_sel(w_e_a, w_m_a);
                r_fwd_b <= f_sel(w_e_b, w_m_b);
            end else begin
                r_fwd_a <= 2'b00;
                r_fwd_b <= 2'b00;
            end
            if ((w_class == CL_STALL) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            if ((w_class == CL_REDIRECT) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
        end
    end

    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: one forwarding instance (16-bit counters) and one
// interlock-only instance (4-bit counters) share the same stimulus; each is
// compared every cycle against a pipeline-occupancy model, plus directed checks.
module tb_hazard_sequencer;
    logic clk;
    logic reset;

    hazard_sequencer_if #(.REGW(5), .CNTW(16)) if_f ();
    hazard_sequencer_if #(.REGW(5), .CNTW(4))  if_n ();

    hazard_sequencer #(.FORWARDING(1), .REGW(5), .CNTW(16)) dut_f (
        .i_clk(clk), .i_reset(reset), .bus(if_f));
    hazard_sequencer #(.FORWARDING(0), .REGW(5), .CNTW(4)) dut_n (
        .i_clk(clk), .i_reset(reset), .bus(if_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit       rst;
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit [4:0] rd;
        bit       wen;
        bit       lw;
        bit       red;
        bit       busy;
    } stim_t;

    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       lw;
    } inst_t;

    // Model: instructions occupying ID/EX, EX/MEM, MEM/WB for each instance (0 = fwd, 1 = interlock).
    inst_t sb [2][3];
    int    m_fa [2];
    int    m_fb [2];
    int    c_st [2];
    int    c_fl [2];

    logic [6:0]  o_en [2];
    logic [1:0]  o_fa [2];
    logic [1:0]  o_fb [2];
    logic [31:0] o_sc [2];
    logic [31:0] o_fc [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, d, cyc_no, obs, exp);
        end
    endtask

    function automatic bit reads(input inst_t e, input bit [4:0] rs, input bit u);
        return e.v && (e.rd != 5'd0) && (e.rd == rs) && u;
    endfunction

    // 0 run, 1 stall, 2 redirect, 3 freeze
    function automatic int klass(input int d, input stim_t s);
        bit dep_e, dep_m, haz;
        dep_e = reads(sb[d][0], s.rs1, s.u1) || reads(sb[d][0], s.rs2, s.u2);
        dep_m = reads(sb[d][1], s.rs1, s.u1) || reads(sb[d][1], s.rs2, s.u2);
        haz   = (d == 0) ? (dep_e && sb[d][0].lw) : (dep_e || dep_m);
        if (s.busy) return 3;
        if (s.red) return 2;
        if (s.v && haz) return 1;
        return 0;
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_bubble, idex_en, exmem_en, memwb_en}
    function automatic logic [6:0] exp_en(input int k);
        case (k)
            0:       return 7'b1100111;
            1:       return 7'b0001111;
            2:       return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int src_sel(input int d, input bit [4:0] rs, input bit u);
        if (reads(sb[d][0], rs, u)) return 1;
        if (reads(sb[d][1], rs, u)) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] sat(input int c, input int maxv);
        return (c > maxv) ? 32'(maxv) : 32'(c);
    endfunction

    task automatic cyc(input stim_t s);
        int    kk [2];
        inst_t ne;
        @(negedge clk);
        reset = s.rst;
        if_f.id_valid = s.v;   if_n.id_valid = s.v;
        if_f.id_rs1 = s.rs1;   if_n.id_rs1 = s.rs1;
        if_f.id_rs2 = s.rs2;   if_n.id_rs2 = s.rs2;
        if_f.id_use_rs1 = s.u1; if_n.id_use_rs1 = s.u1;
        if_f.id_use_rs2 = s.u2; if_n.id_use_rs2 = s.u2;
        if_f.id_rd = s.rd;     if_n.id_rd = s.rd;
        if_f.id_wen = s.wen;   if_n.id_wen = s.wen;
        if_f.id_lw = s.lw;     if_n.id_lw = s.lw;
        if_f.ex_redirect = s.red; if_n.ex_redirect = s.red;
        if_f.mem_busy = s.busy;   if_n.mem_busy = s.busy;
        #1;
        o_en[0] = {if_f.pc_en, if_f.ifid_en, if_f.ifid_flush, if_f.idex_bubble,
                   if_f.idex_en, if_f.exmem_en, if_f.memwb_en};
        o_en[1] = {if_n.pc_en, if_n.ifid_en, if_n.ifid_flush, if_n.idex_bubble,
                   if_n.idex_en, if_n.exmem_en, if_n.memwb_en};
        o_fa[0] = if_f.fwd_a; o_fb[0] = if_f.fwd_b;
        o_fa[1] = if_n.fwd_a; o_fb[1] = if_n.fwd_b;
        o_sc[0] = 32'(if_f.stall_cnt); o_fc[0] = 32'(if_f.flush_cnt);
        o_sc[1] = 32'(if_n.stall_cnt); o_fc[1] = 32'(if_n.flush_cnt);
        for (int d = 0; d < 2; d++) begin
            kk[d] = klass(d, s);
            if (!s.rst) begin
                chk("enables", d, 32'(o_en[d]), 32'(exp_en(kk[d])));
                chk("fwd_a", d, 32'(o_fa[d]), 32'(m_fa[d]));
                chk("fwd_b", d, 32'(o_fb[d]), 32'(m_fb[d]));
                chk("stall_cnt", d, o_sc[d], sat(c_st[d], (d == 0) ? 65535 : 15));
                chk("flush_cnt", d, o_fc[d], sat(c_fl[d], (d == 0) ? 65535 : 15));
            end
        end
        @(posedge clk);
        cyc_no++;
        for (int d = 0; d < 2; d++) begin
            if (s.rst) begin
                for (int i = 0; i < 3; i++) sb[d][i] = '0;
                m_fa[d] = 0; m_fb[d] = 0; c_st[d] = 0; c_fl[d] = 0;
            end else if (kk[d] != 3) begin
                if (kk[d] == 0 && d == 0) begin
                    m_fa[d] = src_sel(d, s.rs1, s.u1);
                    m_fb[d] = src_sel(d, s.rs2, s.u2);
                end else begin
                    m_fa[d] = 0; m_fb[d] = 0;
                end
                ne = '0;
                if (kk[d] == 0) begin
                    ne.v = s.v & s.wen; ne.rd = s.rd; ne.lw = s.lw;
                end
                sb[d][2] = sb[d][1];
                sb[d][1] = sb[d][0];
                sb[d][0] = ne;
                if (kk[d] == 1) c_st[d]++;
                if (kk[d] == 2) c_fl[d]++;
            end
        end
    endtask

    function automatic stim_t s_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t s_rst();
        stim_t s;
        s = '0; s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_wr(input bit [4:0] rd, input bit lw);
        stim_t s;
        s = '0; s.v = 1'b1; s.rd = rd; s.wen = 1'b1; s.lw = lw;
        return s;
    endfunction

    function automatic stim_t s_rd(input bit [4:0] a, input bit [4:0] b, input bit [4:0] rd);
        stim_t s;
        s = '0; s.v = 1'b1; s.rs1 = a; s.rs2 = b; s.u1 = 1'b1; s.u2 = 1'b1;
        s.rd = rd; s.wen = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1;

        // Reset then idle
        cyc(s_rst()); cyc(s_rst());
        cyc(s_idle()); cyc(s_idle());
        for (int d = 0; d < 2; d++) begin
            chk("rst_en", d, 32'(o_en[d]), 32'h67);
            chk("rst_fwd", d, 32'({o_fa[d], o_fb[d]}), 32'h0);
            chk("rst_cnt", d, o_sc[d] | o_fc[d], 32'h0);
        end

        // Load-use with forwarding: lw x5 ; add x6,x5,x1
        cyc(s_rst());
        cyc(s_wr(5'd5, 1'b1));
        cyc(s_rd(5'd5, 5'd1, 5'd6));
        chk("lu_stall_en", 0, 32'(o_en[0]), 32'h0F);
        cyc(s_rd(5'd5, 5'd1, 5'd6));
        chk("lu_resume_en", 0, 32'(o_en[0]), 32'h67);
        cyc(s_idle());
        chk("lu_fwd_a", 0, 32'(o_fa[0]), 32'h2);
        chk("lu_stall_cnt", 0, o_sc[0], 32'h1);

        // add x5 ; sub x7,x5,x5 -> forward from EX/MEM, then the same with x0
        cyc(s_rst());
        cyc(s_wr(5'd5, 1'b0));
        cyc(s_rd(5'd5, 5'd5, 5'd7));
        chk("alu_nostall_en", 0, 32'(o_en[0]), 32'h67);
        cyc(s_idle());
        chk("alu_fwd_ab", 0, 32'({o_fa[0], o_fb[0]}), 32'h5);
        cyc(s_wr(5'd0, 1'b0));
        cyc(s_rd(5'd0, 5'd0, 5'd7));
        cyc(s_idle());
        chk("x0_fwd_ab", 0, 32'({o_fa[0], o_fb[0]}), 32'h0);

        // Interlock-only: addi x3 ; reader of x3 -> two stalls
        cyc(s_rst());
        cyc(s_wr(5'd3, 1'b0));
        cyc(s_rd(5'd3, 5'd0, 5'd4));
        chk("il_stall1", 1, 32'(o_en[1]), 32'h0F);
        cyc(s_rd(5'd3, 5'd0, 5'd4));
        chk("il_stall2", 1, 32'(o_en[1]), 32'h0F);
        cyc(s_rd(5'd3, 5'd0, 5'd4));
        chk("il_run", 1, 32'(o_en[1]), 32'h67);
        cyc(s_idle());
        chk("il_fwd_a", 1, 32'(o_fa[1]), 32'h0);
        chk("il_stall_cnt", 1, o_sc[1], 32'h2);

        // Hazard coincident with redirect
        cyc(s_rst());
        cyc(s_wr(5'd5, 1'b1));
        s = s_rd(5'd5, 5'd1, 5'd6); s.red = 1'b1;
        cyc(s);
        chk("red_en", 0, 32'(o_en[0]), 32'h7F);
        cyc(s_idle());
        chk("red_stall_cnt", 0, o_sc[0], 32'h0);
        chk("red_flush_cnt", 0, o_fc[0], 32'h1);

        // mem_busy for 3 cycles during a load-use stall
        cyc(s_rst());
        cyc(s_wr(5'd5, 1'b1));
        s = s_rd(5'd5, 5'd1, 5'd6); s.busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(s);
            chk("frz_en", 0, 32'(o_en[0]), 32'h0);
        end
        chk("frz_stall_cnt", 0, o_sc[0], 32'h0);
        cyc(s_rd(5'd5, 5'd1, 5'd6));
        chk("frz_then_stall", 0, 32'(o_en[0]), 32'h0F);
        cyc(s_rd(5'd5, 5'd1, 5'd6));
        chk("frz_then_run", 0, 32'(o_en[0]), 32'h67);
        cyc(s_idle());
        chk("frz_stall_cnt1", 0, o_sc[0], 32'h1);
        chk("frz_fwd_a", 0, 32'(o_fa[0]), 32'h2);

        // Reset in the middle of a freeze
        cyc(s_wr(5'd2, 1'b1));
        s = s_rd(5'd2, 5'd2, 5'd3); s.busy = 1'b1;
        cyc(s);
        cyc(s_rst());
        cyc(s_rd(5'd2, 5'd2, 5'd3));
        chk("rst_mid_frz_en", 0, 32'(o_en[0]), 32'h67);

        // Counter saturation on the 4-bit instance
        cyc(s_rst());
        s = s_idle(); s.red = 1'b1;
        for (int i = 0; i < 20; i++) cyc(s);
        cyc(s_idle());
        chk("sat_flush_n", 1, o_fc[1], 32'hF);
        chk("sat_flush_f", 0, o_fc[0], 32'd20);
        cyc(s_rst());
        for (int i = 0; i < 10; i++) begin
            cyc(s_wr(5'd3, 1'b0));
            for (int j = 0; j < 3; j++) cyc(s_rd(5'd3, 5'd3, 5'd4));
        end
        cyc(s_idle());
        chk("sat_stall_n", 1, o_sc[1], 32'hF);
        chk("sat_stall_f", 0, o_sc[0], 32'h0);

        // Randomized traffic against the model
        cyc(s_rst());
        for (int i = 0; i < 800; i++) begin
            s = '0;
            s.rst  = ($urandom_range(0, 49) == 0);
            s.v    = ($urandom_range(0, 3) != 0);
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom_range(0, 1));
            s.u2   = 1'($urandom_range(0, 1));
            s.rd   = 5'($urandom_range(0, 3));
            s.wen  = ($urandom_range(0, 3) != 0);
            s.lw   = ($urandom_range(0, 2) == 0);
            s.red  = ($urandom_range(0, 9) == 0);
            s.busy = ($urandom_range(0, 5) == 0);
            cyc(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
